// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_pkg
// Description : Shared types and constants for the edge-to-RGB converter:
//               FSM state type, default frame geometry, RGB pixel width and
//               a helper that sizes the frame counters.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_pkg;

    // Converter FSM states
    typedef enum logic [0:0] {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    // Default frame geometry
    localparam int c_DEFAULT_IMG_WIDTH  = 720;
    localparam int c_DEFAULT_IMG_HEIGHT = 540;

    // Width of one packed {R,G,B} output pixel
    localparam int c_RGB_WIDTH = 24;

    // Counter width for a dimension of n entries. A dimension of 1 still
    // needs a 1-bit register to stay a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : edge_pkg
`default_nettype wire

// File: rtl/frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : frame_counter
// Description : Column/row position counters for a raster frame. Advances
//               one pixel per i_advance, wrapping col at IMG_WIDTH-1 and row
//               at IMG_HEIGHT-1. Flags the last pixel of the frame and, with
//               EDGE_TO_RGB_BORDER_MASK_EN defined, whether the current
//               pixel lies on the frame border.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_advance           - current pixel consumed, step position
//               o_border            - (macro only) current pixel on border
//               o_last_pixel        - current pixel is last of frame
// Config      : EDGE_TO_RGB_BORDER_MASK_EN enables the o_border output
// Revision    : 1.0 - initial release
// ============================================================================
module frame_counter
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = c_DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = c_DEFAULT_IMG_HEIGHT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_advance,
`ifdef EDGE_TO_RGB_BORDER_MASK_EN
    output logic o_border,
`endif
    output logic o_last_pixel
);

    localparam int c_COL_W = cnt_width(IMG_WIDTH);
    localparam int c_ROW_W = cnt_width(IMG_HEIGHT);

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic               w_col_last;
    logic               w_row_last;

    assign w_col_last = (r_col == c_COL_LAST);
    assign w_row_last = (r_row == c_ROW_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_advance) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + c_ROW_W'(1);
            end else begin
                r_col <= r_col + c_COL_W'(1);
            end
        end
    end

    assign o_last_pixel = w_col_last & w_row_last;

`ifdef EDGE_TO_RGB_BORDER_MASK_EN
    assign o_border = (r_col == '0) | w_col_last | (r_row == '0) | w_row_last;
`endif

endmodule : frame_counter
`default_nettype wire

// File: rtl/edge_to_rgb.sv
`default_nettype none
// ============================================================================
// Module      : edge_to_rgb
// Description : Converts an 8-bit edge/grey stream into 24-bit RGB pixels by
//               replicating each byte into R, G and B. One byte is read from
//               a first-word-fall-through FIFO, held in a register, then
//               written to the downstream pixel FIFO (1 pixel / 2 clocks).
//               frame_done pulses on the write of the last pixel of a frame.
// Ports       : clock, reset        - clock, synchronous active-high reset
//               in_rd_en/in_empty/in_dout   - upstream 8-bit FWFT FIFO
//               out_wr_en/out_full/out_din  - downstream 24-bit FIFO
//               frame_done          - last-pixel-of-frame write pulse
// Config      : EDGE_TO_RGB_BORDER_MASK_EN - blacks out border pixels
//               (row 0, last row, col 0, last col); pixels still counted.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_to_rgb
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = c_DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = c_DEFAULT_IMG_HEIGHT
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   in_rd_en,
    input  logic                   in_empty,
    input  logic [7:0]             in_dout,
    output logic                   out_wr_en,
    input  logic                   out_full,
    output logic [c_RGB_WIDTH-1:0] out_din,
    output logic                   frame_done
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [7:0]             r_pix_q;
    logic                   w_rd;
    logic                   w_wr;
    logic                   w_last_pixel;
    logic [c_RGB_WIDTH-1:0] w_pixel;

    // ------------------------------------------------------------------------
    // State and pixel holding register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_READ;
            r_pix_q <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_rd) begin
                r_pix_q <= in_dout;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and strobes. Strobes are forced low during reset because the
    // state register may still hold S_WRITE in the first reset cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        if (!reset) begin
            case (r_state)
                S_READ: begin
                    if (!in_empty) begin
                        w_rd         = 1'b1;
                        w_state_next = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!out_full) begin
                        w_wr         = 1'b1;
                        w_state_next = S_READ;
                    end
                end
                default: begin
                    w_state_next = S_READ;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Frame position tracking
    // ------------------------------------------------------------------------
`ifdef EDGE_TO_RGB_BORDER_MASK_EN
    logic w_border;

    frame_counter #(
        .IMG_WIDTH    (IMG_WIDTH),
        .IMG_HEIGHT   (IMG_HEIGHT)
    ) u_frame_counter (
        .clk          (clock),
        .rst          (reset),
        .i_advance    (w_wr),
        .o_border     (w_border),
        .o_last_pixel (w_last_pixel)
    );

    assign w_pixel = w_border ? '0 : {3{r_pix_q}};
`else
    frame_counter #(
        .IMG_WIDTH    (IMG_WIDTH),
        .IMG_HEIGHT   (IMG_HEIGHT)
    ) u_frame_counter (
        .clk          (clock),
        .rst          (reset),
        .i_advance    (w_wr),
        .o_last_pixel (w_last_pixel)
    );

    assign w_pixel = {3{r_pix_q}};
`endif

    // ------------------------------------------------------------------------
    // Outputs: pixel data comes only from the held register, never in_dout
    // ------------------------------------------------------------------------
    assign in_rd_en   = w_rd;
    assign out_wr_en  = w_wr;
    assign out_din    = reset ? '0 : w_pixel;
    assign frame_done = w_wr & w_last_pixel;

endmodule : edge_to_rgb
`default_nettype wire
